// File: rtl/tower_draw_arbiter.sv
// ---------------------------------------------------------------------------
// tower_draw_arbiter
//
// Purpose:
//   Arbitrates N_STAGES tower-drawer channels onto a single VGA pixel port and
//   a single map-memory write port. One channel is granted at a time, and the
//   grant stays locked until that channel's tower session completes (ch_done)
//   or is aborted (its draw request falls). The block also keeps a saturating
//   placed-tower count per stage and the done handshake for each stage.
//
// Configuration macro:
//   TOWER_ARB_ROUND_ROBIN_EN - when defined, IDLE selection is round-robin
//                              and starts after the last granted stage. When
//                              undefined, the lowest eligible index wins.
//
// Ports:
//   clk_i                 system clock
//   reset_i               synchronous, active-high reset
//   stage_draw_tower_i    per-stage draw request (level)
//   ch_wren_i             per-channel VGA write enable
//   ch_coord_i            packed per-channel coordinates (COORD_W each)
//   ch_colour_i           packed per-channel colours (COLOUR_W each)
//   ch_erase_addr_i       packed per-channel map erase addresses
//   ch_map_wr_i           per-channel map write request
//   ch_done_i             per-channel one-cycle tower-finished pulse
//   tower_wren_o          muxed VGA write enable (registered)
//   coord_o               muxed coordinate (registered)
//   colour_o              muxed colour (registered)
//   erase_mem_address_o   muxed map erase address (registered)
//   write_map_en_o        muxed map write enable (registered)
//   grant_o               one-hot granted channel, zero when idle
//   stage_tower_done_o    per-stage done level to the control FSM
//   tower_count_o         packed per-stage placed-tower counts (CNT_W each)
//   limit_reached_o       per-stage count == MAX_TOWERS
//   multi_req_err_o       sticky: several eligible requests seen while idle
// ---------------------------------------------------------------------------
module tower_draw_arbiter #(
  parameter int N_STAGES   = 3,
  parameter int COORD_W    = 15,
  parameter int COLOUR_W   = 9,
  parameter int CNT_W      = 4,
  parameter int MAX_TOWERS = 10
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [N_STAGES-1:0]          stage_draw_tower_i,
  input  logic [N_STAGES-1:0]          ch_wren_i,
  input  logic [N_STAGES*COORD_W-1:0]  ch_coord_i,
  input  logic [N_STAGES*COLOUR_W-1:0] ch_colour_i,
  input  logic [N_STAGES*COORD_W-1:0]  ch_erase_addr_i,
  input  logic [N_STAGES-1:0]          ch_map_wr_i,
  input  logic [N_STAGES-1:0]          ch_done_i,
  output logic                         tower_wren_o,
  output logic [COORD_W-1:0]           coord_o,
  output logic [COLOUR_W-1:0]          colour_o,
  output logic [COORD_W-1:0]           erase_mem_address_o,
  output logic                         write_map_en_o,
  output logic [N_STAGES-1:0]          grant_o,
  output logic [N_STAGES-1:0]          stage_tower_done_o,
  output logic [N_STAGES*CNT_W-1:0]    tower_count_o,
  output logic [N_STAGES-1:0]          limit_reached_o,
  output logic                         multi_req_err_o
);

  localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_e;

  state_e               state_q;
  logic [N_STAGES-1:0]  grant_q;
  logic [IDX_W-1:0]     gidx_q;
  logic [N_STAGES-1:0]  done_q;
  logic [N_STAGES-1:0]  limit_q;
  logic [CNT_W-1:0]     count_q [N_STAGES];
  logic                 err_q;
  logic                 wren_q;
  logic                 map_q;
  logic [COORD_W-1:0]   coord_q;
  logic [COORD_W-1:0]   erase_q;
  logic [COLOUR_W-1:0]  colour_q;
`ifdef TOWER_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]     last_grant_q;
  int                   cand;
  logic                 found;
`endif

  logic [N_STAGES-1:0]  eligible;
  logic                 multi_req;
  logic [IDX_W-1:0]     sel_idx;
  logic                 g_wren, g_map, g_done, g_req;
  logic [COORD_W-1:0]   g_coord, g_erase;
  logic [COLOUR_W-1:0]  g_colour;
  logic [CNT_W-1:0]     count_d;

  // Stages that already hit the tower limit never compete for the grant.
  assign eligible  = stage_draw_tower_i & ~limit_q;
  // Clearing the lowest set bit leaves something only if two or more are set.
  assign multi_req = |(eligible & (eligible - N_STAGES'(1)));

`ifdef TOWER_ARB_ROUND_ROBIN_EN
  // Round-robin: first eligible stage found walking upward from last grant + 1.
  always_comb begin
    sel_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < N_STAGES; k++) begin
      cand = (int'(last_grant_q) + 1 + k) % N_STAGES;
      if (!found && eligible[cand]) begin
        found   = 1'b1;
        sel_idx = IDX_W'(cand);
      end
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest eligible index.
  always_comb begin
    sel_idx = '0;
    for (int k = N_STAGES - 1; k >= 0; k--) begin
      if (eligible[k]) sel_idx = IDX_W'(k);
    end
  end
`endif

  // Only the granted channel is looked at; every other channel is invisible.
  assign g_wren   = ch_wren_i[gidx_q];
  assign g_map    = ch_map_wr_i[gidx_q];
  assign g_done   = ch_done_i[gidx_q];
  assign g_req    = stage_draw_tower_i[gidx_q];
  assign g_coord  = ch_coord_i[gidx_q*COORD_W +: COORD_W];
  assign g_erase  = ch_erase_addr_i[gidx_q*COORD_W +: COORD_W];
  assign g_colour = ch_colour_i[gidx_q*COLOUR_W +: COLOUR_W];

  // Saturating increment of the granted stage's tower counter.
  assign count_d = (count_q[gidx_q] < CNT_W'(MAX_TOWERS)) ?
                   count_q[gidx_q] + CNT_W'(1) : count_q[gidx_q];

  // Arbiter FSM. Muxed pixel outputs default to zero and are only loaded
  // while a session is live, so they read zero one cycle after leaving
  // GRANT. The done level defaults to the "blocked at limit" indication,
  // and the session owner's bit is then forced on where needed.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      done_q   <= '0;
      limit_q  <= '0;
      err_q    <= 1'b0;
      wren_q   <= 1'b0;
      map_q    <= 1'b0;
      coord_q  <= '0;
      erase_q  <= '0;
      colour_q <= '0;
      for (int i = 0; i < N_STAGES; i++) count_q[i] <= '0;
`ifdef TOWER_ARB_ROUND_ROBIN_EN
      last_grant_q <= IDX_W'(N_STAGES - 1);
`endif
    end else begin
      wren_q   <= 1'b0;
      map_q    <= 1'b0;
      coord_q  <= '0;
      erase_q  <= '0;
      colour_q <= '0;
      done_q   <= stage_draw_tower_i & limit_q;
      case (state_q)
        IDLE: begin
          if (|eligible) begin
            grant_q <= N_STAGES'(1) << sel_idx;
            gidx_q  <= sel_idx;
            state_q <= GRANT;
`ifdef TOWER_ARB_ROUND_ROBIN_EN
            last_grant_q <= sel_idx;
`endif
            if (multi_req) err_q <= 1'b1;
          end
        end
        GRANT: begin
          // A pixel presented with ch_done is still forwarded; an abort
          // (request low without done) forwards nothing.
          if (g_done || g_req) begin
            wren_q   <= g_wren;
            map_q    <= g_map;
            coord_q  <= g_coord;
            erase_q  <= g_erase;
            colour_q <= g_colour;
          end
          if (g_done) begin
            count_q[gidx_q] <= count_d;
            limit_q[gidx_q] <= (count_d == CNT_W'(MAX_TOWERS));
            done_q[gidx_q]  <= 1'b1;
            if (g_req) begin
              state_q <= HOLD;
            end else begin
              // Done and drop together: single-cycle done pulse, back to IDLE.
              state_q <= IDLE;
              grant_q <= '0;
            end
          end else if (!g_req) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        HOLD: begin
          if (!g_req) begin
            state_q <= IDLE;
            grant_q <= '0;
          end else begin
            done_q[gidx_q] <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // Unpacked counters flattened onto the packed output bus.
  always_comb begin
    tower_count_o = '0;
    for (int i = 0; i < N_STAGES; i++) tower_count_o[i*CNT_W +: CNT_W] = count_q[i];
  end

  assign tower_wren_o        = wren_q;
  assign coord_o             = coord_q;
  assign colour_o            = colour_q;
  assign erase_mem_address_o = erase_q;
  assign write_map_en_o      = map_q;
  assign grant_o             = grant_q;
  assign stage_tower_done_o  = done_q;
  assign limit_reached_o     = limit_q;
  assign multi_req_err_o     = err_q;

endmodule

// File: tb/tb_tower_draw_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tower_draw_arbiter
//
// Directed bench for tower_draw_arbiter (3 stages). A session-level model
// (who owns the port, whether the owner has finished, how many towers each
// stage has placed) predicts every output each cycle, and a set of literal
// expectations at key points pins that model down. Works for both the
// default and TOWER_ARB_ROUND_ROBIN_EN builds.
// ---------------------------------------------------------------------------
module tb_tower_draw_arbiter;

  localparam int N    = 3;
  localparam int CW   = 15;
  localparam int LW   = 9;
  localparam int NW   = 4;
  localparam int MAXT = 10;

`ifdef TOWER_ARB_ROUND_ROBIN_EN
  localparam int FIRST_CH  = 2;
  localparam int SECOND_CH = 0;
  localparam int THIRD_CH  = 2;
`else
  localparam int FIRST_CH  = 0;
  localparam int SECOND_CH = 2;
  localparam int THIRD_CH  = 0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    stage_draw_tower, ch_wren, ch_map_wr, ch_done;
  logic [N*CW-1:0] ch_coord, ch_erase_addr;
  logic [N*LW-1:0] ch_colour;
  logic            tower_wren, write_map_en, multi_req_err;
  logic [CW-1:0]   coord, erase_mem_address;
  logic [LW-1:0]   colour;
  logic [N-1:0]    grant, stage_tower_done, limit_reached;
  logic [N*NW-1:0] tower_count;

  int checks = 0;
  int errors = 0;

  // Model state: session owner (-1 = nobody), finished flag, counts.
  int           mOwner;
  bit           mHold;
  int           mCnt [N];
  bit           mErr;
  int           mLast;
  logic         eWren, eMap;
  logic [CW-1:0] eCoord, eErase;
  logic [LW-1:0] eColour;
  logic [N-1:0]  eDone;

  tower_draw_arbiter #(
    .N_STAGES(N), .COORD_W(CW), .COLOUR_W(LW), .CNT_W(NW), .MAX_TOWERS(MAXT)
  ) dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .stage_draw_tower_i (stage_draw_tower),
    .ch_wren_i          (ch_wren),
    .ch_coord_i         (ch_coord),
    .ch_colour_i        (ch_colour),
    .ch_erase_addr_i    (ch_erase_addr),
    .ch_map_wr_i        (ch_map_wr),
    .ch_done_i          (ch_done),
    .tower_wren_o       (tower_wren),
    .coord_o            (coord),
    .colour_o           (colour),
    .erase_mem_address_o(erase_mem_address),
    .write_map_en_o     (write_map_en),
    .grant_o            (grant),
    .stage_tower_done_o (stage_tower_done),
    .tower_count_o      (tower_count),
    .limit_reached_o    (limit_reached),
    .multi_req_err_o    (multi_req_err)
  );

  always #5 clk = ~clk;

  // Shared comparison helper for both the per-cycle model check and the
  // literal expectations.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic clearPix();
    eWren   = 1'b0;
    eMap    = 1'b0;
    eCoord  = '0;
    eErase  = '0;
    eColour = '0;
  endtask

  task automatic forwardPix(input int g);
    eWren   = ch_wren[g];
    eMap    = ch_map_wr[g];
    eCoord  = ch_coord[g*CW +: CW];
    eErase  = ch_erase_addr[g*CW +: CW];
    eColour = ch_colour[g*LW +: LW];
  endtask

  // Advance the session model by one clock using the inputs seen at the edge.
  task automatic modelStep();
    logic [N-1:0] lim;
    int           elig[$];
    int           g;
    if (reset) begin
      mOwner = -1;
      mHold  = 1'b0;
      mErr   = 1'b0;
      mLast  = N - 1;
      for (int i = 0; i < N; i++) mCnt[i] = 0;
      clearPix();
      eDone = '0;
      return;
    end
    for (int i = 0; i < N; i++) lim[i] = (mCnt[i] == MAXT);
    clearPix();
    eDone = stage_draw_tower & lim;
    if (mOwner < 0) begin
      for (int k = 0; k < N; k++) begin
`ifdef TOWER_ARB_ROUND_ROBIN_EN
        int i = (mLast + 1 + k) % N;
`else
        int i = k;
`endif
        if (stage_draw_tower[i] && !lim[i]) elig.push_back(i);
      end
      if (elig.size() > 0) begin
        mOwner = elig[0];
        mHold  = 1'b0;
        mLast  = elig[0];
        if (elig.size() > 1) mErr = 1'b1;
      end
    end else begin
      g = mOwner;
      if (!mHold) begin
        if (ch_done[g]) begin
          forwardPix(g);
          if (mCnt[g] < MAXT) mCnt[g] = mCnt[g] + 1;
          eDone[g] = 1'b1;
          if (stage_draw_tower[g]) mHold = 1'b1;
          else                     mOwner = -1;
        end else if (!stage_draw_tower[g]) begin
          mOwner = -1;
        end else begin
          forwardPix(g);
        end
      end else begin
        if (stage_draw_tower[g]) eDone[g] = 1'b1;
        else                     mOwner   = -1;
      end
    end
  endtask

  task automatic compareAll();
    logic [N-1:0]    eGrant, eLimit;
    logic [N*NW-1:0] eCount;
    eGrant = (mOwner < 0) ? '0 : N'(1) << mOwner;
    for (int i = 0; i < N; i++) begin
      eLimit[i]            = (mCnt[i] == MAXT);
      eCount[i*NW +: NW]   = NW'(mCnt[i]);
    end
    checkOutput("model tower_wren", 32'(tower_wren), 32'(eWren));
    checkOutput("model coord", 32'(coord), 32'(eCoord));
    checkOutput("model colour", 32'(colour), 32'(eColour));
    checkOutput("model erase_mem_address", 32'(erase_mem_address), 32'(eErase));
    checkOutput("model write_map_en", 32'(write_map_en), 32'(eMap));
    checkOutput("model grant", 32'(grant), 32'(eGrant));
    checkOutput("model stage_tower_done", 32'(stage_tower_done), 32'(eDone));
    checkOutput("model tower_count", 32'(tower_count), 32'(eCount));
    checkOutput("model limit_reached", 32'(limit_reached), 32'(eLimit));
    checkOutput("model multi_req_err", 32'(multi_req_err), 32'(mErr));
  endtask

  // Model advances on each rising edge; outputs are compared 1 time unit later.
  always @(posedge clk) begin
    modelStep();
    #1;
    compareAll();
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [N-1:0] req, input int cycles);
    stage_draw_tower = req;
    waitCycles(cycles);
  endtask

  task automatic setCh(input int c, input logic wren, input logic [CW-1:0] crd,
                       input logic [LW-1:0] col, input logic [CW-1:0] ers, input logic mw);
    ch_wren[c]             = wren;
    ch_coord[c*CW +: CW]   = crd;
    ch_colour[c*LW +: LW]  = col;
    ch_erase_addr[c*CW +: CW] = ers;
    ch_map_wr[c]           = mw;
  endtask

  task automatic pulseDone(input int c);
    ch_done[c] = 1'b1;
    waitCycles(1);
    ch_done[c] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset            = 1'b1;
    stage_draw_tower = '0;
    ch_wren          = '0;
    ch_map_wr        = '0;
    ch_done          = '0;
    ch_coord         = '0;
    ch_colour        = '0;
    ch_erase_addr    = '0;
    waitCycles(3);
    reset = 1'b0;
    checkOutput("reset grant", 32'(grant), 32'h0);
    checkOutput("reset tower_count", 32'(tower_count), 32'h0);
    checkOutput("reset multi_req_err", 32'(multi_req_err), 32'h0);
    waitCycles(1);

    // Single session on ch1 while ch0/ch2 try to drive 0x7FFF.
    setCh(0, 1'b1, 15'h7FFF, 9'h1AB, 15'h7FFF, 1'b1);
    setCh(2, 1'b1, 15'h7FFF, 9'h155, 15'h7FFF, 1'b1);
    setCh(1, 1'b1, 15'h0101, 9'h1FF, 15'h0201, 1'b1);
    applyStimulus(3'b010, 1);
    checkOutput("single grant", 32'(grant), 32'h2);
    waitCycles(1);
    checkOutput("single coord0", 32'(coord), 32'h0101);
    checkOutput("single colour0", 32'(colour), 32'h1FF);
    setCh(1, 1'b1, 15'h0102, 9'h1FF, 15'h0202, 1'b1);
    ch_done[0] = 1'b1;
    waitCycles(1);
    ch_done[0] = 1'b0;
    checkOutput("single coord1", 32'(coord), 32'h0102);
    setCh(1, 1'b1, 15'h0103, 9'h1FF, 15'h0203, 1'b1);
    waitCycles(1);
    setCh(1, 1'b1, 15'h0104, 9'h1FF, 15'h0204, 1'b1);
    pulseDone(1);
    setCh(1, 1'b0, 15'h0, 9'h0, 15'h0, 1'b0);
    checkOutput("single last coord", 32'(coord), 32'h0104);
    checkOutput("single done", 32'(stage_tower_done), 32'h2);
    checkOutput("single count", 32'(tower_count), 32'h010);
    waitCycles(2);
    checkOutput("single hold done", 32'(stage_tower_done), 32'h2);
    checkOutput("single hold wren", 32'(tower_wren), 32'h0);
    applyStimulus(3'b000, 1);
    checkOutput("single release done", 32'(stage_tower_done), 32'h0);
    checkOutput("single release grant", 32'(grant), 32'h0);
    waitCycles(1);

    // Conflict: two eligible requests from IDLE.
    setCh(0, 1'b1, 15'h0010, 9'h0AA, 15'h0011, 1'b0);
    setCh(2, 1'b1, 15'h0020, 9'h0BB, 15'h0021, 1'b1);
    applyStimulus(3'b101, 1);
    checkOutput("conflict first grant", 32'(grant), 32'(N'(1) << FIRST_CH));
    checkOutput("conflict err", 32'(multi_req_err), 32'h1);
    waitCycles(1);
    pulseDone(FIRST_CH);
    waitCycles(1);
    applyStimulus((FIRST_CH == 0) ? 3'b100 : 3'b001, 2);
    checkOutput("conflict second grant", 32'(grant), 32'(N'(1) << SECOND_CH));
    pulseDone(SECOND_CH);
    waitCycles(1);
    applyStimulus(3'b000, 2);
    applyStimulus(3'b101, 2);
    checkOutput("conflict repeat grant", 32'(grant), 32'(N'(1) << THIRD_CH));
    pulseDone(THIRD_CH);
    waitCycles(1);
    applyStimulus(3'b000, 2);

    // Abort on ch2 mid-stream.
    setCh(0, 1'b0, 15'h0, 9'h0, 15'h0, 1'b0);
    setCh(2, 1'b1, 15'h0200, 9'h055, 15'h0300, 1'b1);
    applyStimulus(3'b100, 2);
    checkOutput("abort streaming wren", 32'(tower_wren), 32'h1);
    applyStimulus(3'b000, 1);
    checkOutput("abort grant", 32'(grant), 32'h0);
    checkOutput("abort wren", 32'(tower_wren), 32'h0);
    checkOutput("abort done", 32'(stage_tower_done), 32'h0);
    waitCycles(1);

    // Reset in the middle of a ch1 grant.
    setCh(2, 1'b0, 15'h0, 9'h0, 15'h0, 1'b0);
    setCh(1, 1'b1, 15'h0055, 9'h011, 15'h0066, 1'b1);
    applyStimulus(3'b010, 2);
    reset            = 1'b1;
    stage_draw_tower = 3'b000;
    waitCycles(1);
    checkOutput("reset mid grant", 32'(grant), 32'h0);
    checkOutput("reset mid wren", 32'(tower_wren), 32'h0);
    checkOutput("reset mid coord", 32'(coord), 32'h0);
    checkOutput("reset mid count", 32'(tower_count), 32'h0);
    checkOutput("reset mid err", 32'(multi_req_err), 32'h0);
    reset = 1'b0;
    setCh(1, 1'b0, 15'h0, 9'h0, 15'h0, 1'b0);
    waitCycles(2);

    // Saturation: ten sessions on ch0, then a blocked eleventh.
    setCh(0, 1'b1, 15'h0300, 9'h0CC, 15'h0301, 1'b1);
    for (int s = 0; s < MAXT; s++) begin
      applyStimulus(3'b001, 2);
      pulseDone(0);
      waitCycles(1);
      applyStimulus(3'b000, 2);
    end
    checkOutput("sat count", 32'(tower_count), 32'h00A);
    checkOutput("sat limit", 32'(limit_reached), 32'h1);
    applyStimulus(3'b001, 2);
    checkOutput("sat blocked grant", 32'(grant), 32'h0);
    checkOutput("sat blocked done", 32'(stage_tower_done), 32'h1);
    waitCycles(1);
    checkOutput("sat blocked done held", 32'(stage_tower_done), 32'h1);
    applyStimulus(3'b000, 2);
    checkOutput("sat blocked done clear", 32'(stage_tower_done), 32'h0);
    setCh(0, 1'b0, 15'h0, 9'h0, 15'h0, 1'b0);

    // Done and request drop in the same cycle on ch1.
    setCh(1, 1'b1, 15'h0400, 9'h077, 15'h0401, 1'b0);
    applyStimulus(3'b010, 2);
    ch_done[1]       = 1'b1;
    stage_draw_tower = 3'b000;
    waitCycles(1);
    ch_done[1] = 1'b0;
    checkOutput("same-cycle done", 32'(stage_tower_done), 32'h2);
    checkOutput("same-cycle grant", 32'(grant), 32'h0);
    checkOutput("same-cycle last pixel", 32'(tower_wren), 32'h1);
    checkOutput("same-cycle count", 32'(tower_count), 32'h01A);
    waitCycles(1);
    checkOutput("same-cycle done pulse end", 32'(stage_tower_done), 32'h0);
    waitCycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
